// File: rtl/fixed_to_bcd_fmt.sv
// rtl/fixed_to_bcd_fmt.sv - signed fixed-point to sign + packed BCD integer/fraction converter
//
// Purpose:
//   Converts one signed Q(N-FRAC).FRAC two's-complement value into a sign flag,
//   INT_DIG packed BCD integer digits (double-dabble) and FRAC_DIG truncated
//   packed BCD fraction digits (repeated multiply by ten).
//   Iterative, one conversion at a time, START/BUSY/VALID handshake.
//
// Ports:
//   CLK       in   1            clock, all state on posedge
//   RST       in   1            asynchronous active-low reset
//   START     in   1            convert request, sampled only in IDLE
//   DATA_IN   in   N            signed fixed-point value, sampled with START
//   BUSY      out  1            high from the capture edge until VALID
//   VALID     out  1            one-cycle pulse, result outputs updated
//   SIGN      out  1            1 = captured value was negative
//   INT_BCD   out  4*INT_DIG    integer magnitude, MS digit in top nibble
//   FRAC_BCD  out  4*FRAC_DIG   fraction digits, first digit after point on top
//   OVF       out  1            integer magnitude exceeded INT_DIG digits (INT_BCD = all 9s)

module fixed_to_bcd_fmt #(
   parameter int N        = 32,
   parameter int FRAC     = 16,
   parameter int INT_DIG  = 5,
   parameter int FRAC_DIG = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    START,
   input  logic [N-1:0]            DATA_IN,
   output logic                    BUSY,
   output logic                    VALID,
   output logic                    SIGN,
   output logic [4*INT_DIG-1:0]    INT_BCD,
   output logic [4*FRAC_DIG-1:0]   FRAC_BCD,
   output logic                    OVF
);

   localparam int IW   = N - FRAC;
   localparam int IB   = 4 * INT_DIG;
   localparam int FB   = 4 * FRAC_DIG;
   localparam int CMAX = (IW > FRAC_DIG) ? IW : FRAC_DIG;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] INT_LAST  = CW'(IW - 1);
   localparam logic [CW-1:0] FRAC_LAST = CW'(FRAC_DIG - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_INT  = 2'd1;
   localparam logic [1:0] S_FRAC = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // FSM and work registers
   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   ireg_q, ireg_d;
   logic [FRAC-1:0] freg_q, freg_d;
   logic [IB-1:0]   bcd_q, bcd_d;
   logic [FB-1:0]   fsh_q, fsh_d;
   logic            sign_w_q, sign_w_d;
   logic            ovf_w_q, ovf_w_d;

   // Output registers
   logic            busy_q, busy_d;
   logic            valid_q, valid_d;
   logic            sign_q, sign_d;
   logic [IB-1:0]   int_q, int_d;
   logic [FB-1:0]   frac_q, frac_d;
   logic            ovf_q, ovf_d;

   // Datapath helpers
   logic [N-1:0]    mag;
   logic [IB-1:0]   adj;
   logic [FRAC+3:0] prod;
   logic [3:0]      digit;

   always_comb begin
      // Negating the most negative value wraps to itself, which read as
      // unsigned is exactly the required magnitude.
      mag = DATA_IN[N-1] ? (-DATA_IN) : DATA_IN;

      // Double-dabble correction: any digit >= 5 would exceed 9 after doubling.
      adj = bcd_q;
      for (int k = 0; k < INT_DIG; k++) begin
         if (bcd_q[4*k +: 4] >= 4'd5) begin
            adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
         end
      end

      // x10 as x8 + x2; the integer part of the product is the next digit.
      prod  = ({4'b0000, freg_q} << 3) + ({4'b0000, freg_q} << 1);
      digit = prod[FRAC+3:FRAC];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ireg_d   = ireg_q;
      freg_d   = freg_q;
      bcd_d    = bcd_q;
      fsh_d    = fsh_q;
      sign_w_d = sign_w_q;
      ovf_w_d  = ovf_w_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      sign_d   = sign_q;
      int_d    = int_q;
      frac_d   = frac_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (START) begin
               sign_w_d = DATA_IN[N-1];
               ireg_d   = mag[N-1:FRAC];
               freg_d   = mag[FRAC-1:0];
               bcd_d    = '0;
               fsh_d    = '0;
               ovf_w_d  = 1'b0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = S_INT;
            end
         end

         S_INT: begin
            bcd_d  = {adj[IB-2:0], ireg_q[IW-1]};
            ireg_d = {ireg_q[IW-2:0], 1'b0};
            // A corrected top digit of 8 or more means the doubled value no
            // longer fits in INT_DIG digits; the bit shifted out flags it.
            ovf_w_d = ovf_w_q | adj[IB-1];
            if (cnt_q == INT_LAST) begin
               cnt_d   = '0;
               state_d = S_FRAC;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_FRAC: begin
            freg_d = prod[FRAC-1:0];
            fsh_d  = (fsh_q << 4) | FB'(digit);
            if (cnt_q == FRAC_LAST) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DONE: begin
            sign_d  = sign_w_q;
            int_d   = ovf_w_q ? {INT_DIG{4'h9}} : bcd_q;
            frac_d  = fsh_q;
            ovf_d   = ovf_w_q;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         ireg_q   <= '0;
         freg_q   <= '0;
         bcd_q    <= '0;
         fsh_q    <= '0;
         sign_w_q <= 1'b0;
         ovf_w_q  <= 1'b0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         sign_q   <= 1'b0;
         int_q    <= '0;
         frac_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ireg_q   <= ireg_d;
         freg_q   <= freg_d;
         bcd_q    <= bcd_d;
         fsh_q    <= fsh_d;
         sign_w_q <= sign_w_d;
         ovf_w_q  <= ovf_w_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         sign_q   <= sign_d;
         int_q    <= int_d;
         frac_q   <= frac_d;
         ovf_q    <= ovf_d;
      end
   end

   assign BUSY     = busy_q;
   assign VALID    = valid_q;
   assign SIGN     = sign_q;
   assign INT_BCD  = int_q;
   assign FRAC_BCD = frac_q;
   assign OVF      = ovf_q;

endmodule
